// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing two CDB broadcast lanes between
// per-unit result FIFOs feeding the reorder buffer.
`ifndef RoB_BITS
`define RoB_BITS 4
`endif

module cdb_arbiter #(
    parameter int REQ_NUM    = 3,
    parameter int ROB_BITS   = `RoB_BITS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush,
    input  logic [REQ_NUM-1:0]          req_valid,
    output logic [REQ_NUM-1:0]          req_ready,
    input  logic [REQ_NUM*ROB_BITS-1:0] req_id,
    input  logic [REQ_NUM*32-1:0]       req_value,
    output logic                        cdb_rdy_1,
    output logic [ROB_BITS-1:0]         cdb_id_1,
    output logic [31:0]                 cdb_value_1,
    output logic                        cdb_rdy_2,
    output logic [ROB_BITS-1:0]         cdb_id_2,
    output logic [31:0]                 cdb_value_2,
    output logic                        pending
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [ROB_BITS-1:0] id_mem    [REQ_NUM][FIFO_DEPTH];
    logic [31:0]         value_mem [REQ_NUM][FIFO_DEPTH];
    logic [PW-1:0]       head      [REQ_NUM];
    logic [PW-1:0]       tail      [REQ_NUM];
    logic [CW-1:0]       count     [REQ_NUM];
    logic [RW-1:0]       rr;
    logic [RW-1:0]       rr_next;
    logic [REQ_NUM-1:0]  nonempty;
    logic [REQ_NUM-1:0]  push;
    logic [REQ_NUM-1:0]  pop;
    logic                g1;
    logic                g2;
    logic [ROB_BITS-1:0] id1;
    logic [ROB_BITS-1:0] id2;
    logic [31:0]         val1;
    logic [31:0]         val2;

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            nonempty[i]  = count[i] != '0;
            req_ready[i] = (count[i] != CW'(FIFO_DEPTH)) && rdy_in && !flush;
            push[i]      = req_valid[i] && req_ready[i];
        end
    end

    assign pending = |nonempty;

    // Walk the units starting at rr; first hit feeds lane 1, second lane 2.
    always_comb begin
        int idx;
        int last;
        idx     = 0;
        last    = 0;
        g1      = 1'b0;
        g2      = 1'b0;
        id1     = '0;
        id2     = '0;
        val1    = '0;
        val2    = '0;
        pop     = '0;
        rr_next = rr;
        for (int off = 0; off < REQ_NUM; off++) begin
            idx = int'(rr) + off;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (i == idx && nonempty[i]) begin
                    if (!g1) begin
                        g1     = 1'b1;
                        id1    = id_mem[i][head[i]];
                        val1   = value_mem[i][head[i]];
                        pop[i] = 1'b1;
                        last   = i;
                    end else if (!g2) begin
                        g2     = 1'b1;
                        id2    = id_mem[i][head[i]];
                        val2   = value_mem[i][head[i]];
                        pop[i] = 1'b1;
                        last   = i;
                    end
                end
            end
        end
        if (g1) begin
            if (last + 1 >= REQ_NUM) rr_next = '0;
            else rr_next = RW'(last + 1);
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (push[i] && !rst_in) begin
                id_mem[i][tail[i]]    <= req_id[i*ROB_BITS +: ROB_BITS];
                value_mem[i][tail[i]] <= req_value[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush)) begin
            rr          <= '0;
            cdb_rdy_1   <= 1'b0;
            cdb_id_1    <= '0;
            cdb_value_1 <= '0;
            cdb_rdy_2   <= 1'b0;
            cdb_id_2    <= '0;
            cdb_value_2 <= '0;
            for (int i = 0; i < REQ_NUM; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else if (rdy_in) begin
            rr          <= rr_next;
            cdb_rdy_1   <= g1;
            cdb_id_1    <= id1;
            cdb_value_1 <= val1;
            cdb_rdy_2   <= g2;
            cdb_id_2    <= id2;
            cdb_value_2 <= val2;
            for (int i = 0; i < REQ_NUM; i++) begin
                if (push[i]) tail[i] <= tail[i] + PW'(1);
                if (pop[i]) head[i] <= head[i] + PW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the two RoB write-back/broadcast lanes between REQ_NUM functional units (ALU RS, LSB, branch unit), giving each unit a small result FIFO and a fair round-robin grant.
- Sits between the execution units and the reorder buffer. Its two output lanes drive the RoB finish ports and the RS/LSB wake-up broadcast.
- Flush (mispredict) discards all buffered results.

Parameters:
- REQ_NUM, 3, number of requesting units (index 0 = ALU, 1 = LSB, 2 = BRU).
- ROB_BITS, `RoB_BITS, width of a RoB entry id.
- FIFO_DEPTH, 2, entries per requester FIFO (power of two, >= 2).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- rdy_in  input  1  global ready; when low the block freezes.
- flush  input  1  discard all buffered results.
- req_valid  input  REQ_NUM  per-unit result valid.
- req_ready  output  REQ_NUM  per-unit FIFO can accept.
- req_id  input  REQ_NUM*ROB_BITS  per-unit RoB id; unit i occupies bits [i*ROB_BITS +: ROB_BITS].
- req_value  input  REQ_NUM*32  per-unit result value; unit i occupies bits [i*32 +: 32].
- cdb_rdy_1  output  1  lane 1 broadcast valid.
- cdb_id_1  output  ROB_BITS  lane 1 RoB id.
- cdb_value_1  output  32  lane 1 value.
- cdb_rdy_2  output  1  lane 2 broadcast valid.
- cdb_id_2  output  ROB_BITS  lane 2 RoB id.
- cdb_value_2  output  32  lane 2 value.
- pending  output  1  at least one FIFO is non-empty.

Behaviour:
- Reset (rst_in=1 at a posedge):
  - All FIFOs empty; rr pointer = 0.
  - cdb_rdy_*/cdb_id_*/cdb_value_* = 0; pending = 0.
  - req_ready = all ones while rdy_in=1.
- Reset has priority over flush and rdy_in. Reset mid-operation drops every entry.
- req_ready[i] is combinational: !full_i && rdy_in && !flush. It depends on the count before the edge, so a full FIFO popping this cycle still shows ready = 0 (no pass-through).
- Push: at a posedge with rdy_in && !flush && req_valid[i] && req_ready[i], {req_id, req_value} is written to FIFO i.
- Grant:
  - Evaluated each cycle on FIFO heads as they stand before the edge.
  - Lane 1 takes the first non-empty FIFO searching from rr upward, mod REQ_NUM.
  - Lane 2 takes the next non-empty FIFO after lane 1's winner, continuing the same search.
  - At most one grant per FIFO per cycle.
- Outputs are registered. At the edge, granted heads are popped and loaded into the lane registers with cdb_rdy_x = 1.
- Ungranted lanes load rdy = 0, id = 0, value = 0. cdb_rdy_2 = 1 implies cdb_rdy_1 = 1.
- Each broadcast is a single-cycle pulse. No downstream backpressure exists; the RoB always accepts.
- Latency: an entry pushed at edge k is granted no earlier than edge k+1. Minimum is valid in cycle 0, broadcast visible in cycle 2.
- rr update: if any grant, rr <= (last granted index + 1) mod REQ_NUM; otherwise rr is unchanged.
- Simultaneous push and pop on one FIFO: count unchanged, order preserved.
- FIFO pointers wrap mod FIFO_DEPTH. Count is ROB_BITS-independent and ranges 0..FIFO_DEPTH.
- Flush (rdy_in=1) at an edge:
  - All FIFOs cleared, rr = 0, lane outputs load 0.
  - Pushes in that cycle are ignored.
  - Grants and pushes resume the following cycle.
- rdy_in=0: all state and outputs hold (including a high cdb_rdy_*); no push, pop, or flush; req_ready = 0.
- pending = OR of FIFO non-empty flags, registered-state derived.
- Duplicate RoB ids are not checked; broadcast order per unit is FIFO order.

Test Plan:
- Reset then unit 0 pushes id=5, value=0x00001234 in cycle 0:
  - cycle 2: cdb_rdy_1=1, id=5, value=0x1234, cdb_rdy_2=0.
  - cycle 3: cdb_rdy_1=0.
- Units 0, 1, 2 push ids 1, 2, 3 in the same cycle:
  - next-next cycle: lanes = (1, 2), rr becomes 2.
  - following cycle: lane 1 = 3, lane 2 idle, rr becomes 0.
- All units valid every cycle with increasing ids:
  - grant pattern (0,1), (2,0), (1,2) repeats.
  - each unit gets 2 of every 3 cycles of bandwidth.
  - FIFOs fill and req_ready toggles.
  - scoreboard shows no lost or reordered id per unit.
- Fill FIFOs of units 0 and 1 (2 entries each), then assert flush for one cycle while unit 2 is valid:
  - next cycle: all cdb_rdy=0, pending=0, rr=0.
  - unit 2's flush-cycle push is absent.
  - a new push of id=9 broadcasts 2 cycles later.
- Drive rdy_in low for 3 cycles while cdb_rdy_1=1 with id=7 and FIFOs hold data:
  - outputs hold id=7, req_ready=0, counts unchanged.
  - after rdy_in returns, grants resume in the same round-robin order.
- Assert rst_in while FIFOs are full and lanes active:
  - next cycle: all outputs 0, pending=0, req_ready all 1.
